// File: rtl/cpu_param.sv
// cpu_param: multi-cycle single-issue core with internal register file, shifter, ALU and status.
// Optional macro CPU_ILLEGAL_TRAP_EN: undefined instructions halt the core until reset.
module cpu_param #(
  parameter int DATA_W         = 16,
  parameter bit RESULT_ON_MOVI = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [15:0]       in,
  output logic              in_ready,
  output logic              w,
  output logic [DATA_W-1:0] out,
  output logic              N,
  output logic              V,
  output logic              Z,
  output logic              illegal
);

  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_GET_A,
    S_GET_B,
    S_EXEC,
    S_WR_IMM,
    S_WR_REG
`ifdef CPU_ILLEGAL_TRAP_EN
    , S_HALT
`endif
  } state_t;

  state_t state, state_next;

  logic [15:0]       ir;
  logic [DATA_W-1:0] regs [8];
  logic [DATA_W-1:0] a, b, c;
  logic [DATA_W-1:0] b_sh, sum, diff, alu_res, imm_ext;
  logic              alu_v;
  logic signed [7:0] imm_s;

  logic [2:0] opcode, rn, rd, rm;
  logic [1:0] op, sh;
  logic       is_movi, is_movr, is_alu, is_cmp;

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign sh     = ir[4:3];
  assign rm     = ir[2:0];

  assign is_movi = (opcode == 3'b110) && (op == 2'b10);
  assign is_movr = (opcode == 3'b110) && (op == 2'b00);
  assign is_alu  = (opcode == 3'b101);
  assign is_cmp  = is_alu && (op == 2'b01);

  assign imm_s   = ir[7:0];
  assign imm_ext = DATA_W'(imm_s);

  assign in_ready = (state == S_WAIT);
  assign w        = in_ready;

  // Single-bit shifter on the B operand only
  always_comb begin
    b_sh = b;
    case (sh)
      2'b01:   b_sh = {b[DATA_W-2:0], 1'b0};
      2'b10:   b_sh = {1'b0, b[DATA_W-1:1]};
      2'b11:   b_sh = {b[DATA_W-1], b[DATA_W-1:1]};
      default: b_sh = b;
    endcase
  end

  assign sum  = a + b_sh;
  assign diff = a - b_sh;

  always_comb begin
    alu_res = '0;
    alu_v   = 1'b0;
    if (is_movr) begin
      alu_res = b_sh;
    end else begin
      case (op)
        2'b00: begin
          alu_res = sum;
          alu_v   = (a[DATA_W-1] == b_sh[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
        end
        2'b01: begin
          alu_res = diff;
          alu_v   = (a[DATA_W-1] != b_sh[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
        end
        2'b10:   alu_res = a & b_sh;
        default: alu_res = ~b_sh;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_WAIT;
    else        state <= state_next;
  end

  // MOV paths skip GET_A; CMP skips the register write-back
  always_comb begin
    state_next = state;
    illegal    = 1'b0;
    case (state)
      S_WAIT:   if (in_valid) state_next = S_DECODE;
      S_DECODE: begin
        if (is_movi)                    state_next = S_WR_IMM;
        else if (is_movr)               state_next = S_GET_B;
        else if (is_alu && op == 2'b11) state_next = S_GET_B;
        else if (is_alu)                state_next = S_GET_A;
        else begin
          illegal = 1'b1;
`ifdef CPU_ILLEGAL_TRAP_EN
          state_next = S_HALT;
`else
          state_next = S_WAIT;
`endif
        end
      end
      S_GET_A:  state_next = S_GET_B;
      S_GET_B:  state_next = S_EXEC;
      S_EXEC:   state_next = is_cmp ? S_WAIT : S_WR_REG;
      S_WR_IMM: state_next = S_WAIT;
      S_WR_REG: state_next = S_WAIT;
`ifdef CPU_ILLEGAL_TRAP_EN
      S_HALT:   state_next = S_HALT;
`endif
      default:  state_next = S_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ir <= '0;
      a  <= '0;
      b  <= '0;
      c  <= '0;
      N  <= 1'b0;
      V  <= 1'b0;
      Z  <= 1'b0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_WAIT:  if (in_valid) ir <= in;
        S_GET_A: a <= regs[rn];
        S_GET_B: b <= regs[rm];
        S_EXEC: begin
          if (!is_cmp) c <= alu_res;
          if (is_alu) begin
            N <= alu_res[DATA_W-1];
            Z <= (alu_res == '0);
            V <= alu_v;
          end
        end
        S_WR_IMM: begin
          regs[rn] <= imm_ext;
          if (RESULT_ON_MOVI) c <= imm_ext;
        end
        S_WR_REG: regs[rd] <= c;
        default: ;
      endcase
    end
  end

  assign out = c;

endmodule

// File: tb/tb_cpu_param.sv
// Self-checking bench for cpu_param: 16-bit and 8-bit instances share one instruction stream.
module tb_cpu_param;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_word = '0;

  logic        rdy16, w16, n16, v16, z16, ill16;
  logic [15:0] out16;
  logic        rdy8, w8, n8, v8, z8, ill8;
  logic [7:0]  out8;

  int checks = 0;
  int errors = 0;

  cpu_param #(.DATA_W(16)) u_dut16 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in_word),
    .in_ready(rdy16), .w(w16), .out(out16), .N(n16), .V(v16), .Z(z16), .illegal(ill16)
  );

  cpu_param #(.DATA_W(8)) u_dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in_word),
    .in_ready(rdy8), .w(w8), .out(out8), .N(n8), .V(v8), .Z(z8), .illegal(ill8)
  );

  always #5 clk = ~clk;

  // Architectural reference model: index 0 is the 16-bit core, index 1 the 8-bit core
  int          wd [2] = '{16, 8};
  logic [31:0] m_reg [2][8];
  logic [31:0] m_c [2];
  logic        m_n [2], m_v [2], m_z [2];

  typedef struct {
    logic [15:0] word;
    logic [15:0] exp_out;
    logic        exp_n, exp_v, exp_z;
  } vec_t;

  vec_t vecs [9];

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < 8; r++) m_reg[k][r] = '0;
      m_c[k] = '0;
      m_n[k] = 1'b0;
      m_v[k] = 1'b0;
      m_z[k] = 1'b0;
    end
  endfunction

  function automatic void model_step(input logic [15:0] ins, output int lat, output bit ill);
    logic [2:0] opc, rn, rd, rm;
    logic [1:0] op, sh;
    opc = ins[15:13]; op = ins[12:11]; rn = ins[10:8];
    rd  = ins[7:5];   sh = ins[4:3];   rm = ins[2:0];
    lat = 0;
    ill = 1'b0;
    if (opc == 3'b110 && op == 2'b10)      lat = 2;
    else if (opc == 3'b110 && op == 2'b00) lat = 4;
    else if (opc == 3'b101)                lat = (op == 2'b01 || op == 2'b11) ? 4 : 5;
    else                                   ill = 1'b1;
    for (int k = 0; k < 2; k++) begin
      logic [31:0] m, top, a, b, r;
      m   = (32'h1 << wd[k]) - 32'h1;
      top = 32'h1 << (wd[k] - 1);
      a   = m_reg[k][rn];
      b   = m_reg[k][rm];
      case (sh)
        2'd1:    b = (b << 1) & m;
        2'd2:    b = b >> 1;
        2'd3:    b = (b >> 1) | (b & top);
        default: ;
      endcase
      if (ill) continue;
      if (opc == 3'b110) begin
        if (op == 2'b10) m_reg[k][rn] = {{24{ins[7]}}, ins[7:0]} & m;
        else begin
          m_c[k] = b;
          m_reg[k][rd] = b;
        end
      end else begin
        r = '0;
        m_v[k] = 1'b0;
        case (op)
          2'd0: begin
            r = (a + b) & m;
            m_v[k] = ((a & top) == (b & top)) && ((r & top) != (a & top));
          end
          2'd1: begin
            r = (a - b) & m;
            m_v[k] = ((a & top) != (b & top)) && ((r & top) != (a & top));
          end
          2'd2:    r = a & b;
          default: r = ~b & m;
        endcase
        m_n[k] = (r & top) != 0;
        m_z[k] = (r == 0);
        if (op != 2'd1) begin
          m_c[k] = r;
          m_reg[k][rd] = r;
        end
      end
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_model();
    check("out16", 32'(out16), m_c[0]);
    check("n16", 32'(n16), 32'(m_n[0]));
    check("v16", 32'(v16), 32'(m_v[0]));
    check("z16", 32'(z16), 32'(m_z[0]));
    check("w16_eq_ready", 32'(w16), 32'(rdy16));
    check("out8", 32'(out8), m_c[1]);
    check("n8", 32'(n8), 32'(m_n[1]));
    check("v8", 32'(v8), 32'(m_v[1]));
    check("z8", 32'(z8), 32'(m_z[1]));
  endtask

  task automatic check_reset_state();
    check("rst_w16", 32'(w16), 32'd1);
    check("rst_out16", 32'(out16), 32'd0);
    check("rst_nvz16", {29'd0, n16, v16, z16}, 32'd0);
    check("rst_ill16", 32'(ill16), 32'd0);
    check("rst_w8", 32'(w8), 32'd1);
    check("rst_out8", 32'(out8), 32'd0);
    check("rst_nvz8", {29'd0, n8, v8, z8}, 32'd0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b0;
    model_reset();
    #1;
    check_reset_state();
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Hands one word to the core, times its completion and compares against the model
  task automatic applyStimulus(input logic [15:0] word);
    int lat, cyc, ill_cnt16, ill_cnt8;
    bit ill;
    model_step(word, lat, ill);
    cyc = 0;
    while (!rdy16 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("ready_before_issue", 32'(rdy16), 32'd1);
    in_word  = word;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid  = 1'b0;
    ill_cnt16 = int'(ill16);
    ill_cnt8  = int'(ill8);
    check("busy_after_accept", 32'(rdy16), 32'd0);
`ifdef CPU_ILLEGAL_TRAP_EN
    if (ill) begin
      repeat (4) begin
        @(posedge clk);
        @(negedge clk);
        ill_cnt16 += int'(ill16);
        ill_cnt8  += int'(ill8);
      end
      check("halt_w16", 32'(w16), 32'd0);
      check("halt_w8", 32'(w8), 32'd0);
      check("illegal_pulses16", 32'(ill_cnt16), 32'd1);
      check("illegal_pulses8", 32'(ill_cnt8), 32'd1);
      apply_reset();
      return;
    end
`endif
    cyc = 0;
    while (!rdy16 && cyc < 20) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      ill_cnt16 += int'(ill16);
      ill_cnt8  += int'(ill8);
    end
    if (ill) check("illegal_w_within_2", 32'(cyc <= 2), 32'd1);
    else     check("latency", 32'(cyc), 32'(lat));
    check("w8_done", 32'(rdy8), 32'd1);
    check("illegal_pulses16", 32'(ill_cnt16), 32'(ill));
    check("illegal_pulses8", 32'(ill_cnt8), 32'(ill));
    check_model();
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] exp_out,
                             input logic exp_n, input logic exp_v, input logic exp_z);
    check({tag, "_out"}, 32'(out16), 32'(exp_out));
    check({tag, "_nvz"}, {29'd0, n16, v16, z16}, {29'd0, exp_n, exp_v, exp_z});
  endtask

  initial begin
    vecs[0] = '{16'hD007, 16'h0000, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'hD102, 16'h0000, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{16'hA148, 16'h0010, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{16'hA800, 16'h0010, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{16'hC062, 16'h0010, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{16'hD380, 16'h0010, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{16'hC09B, 16'hFFC0, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{16'hB8A1, 16'hFFFD, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{16'hB3C4, 16'hFF80, 1'b1, 1'b0, 1'b0};

    model_reset();
    repeat (2) @(negedge clk);
    check_reset_state();
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].word);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_n, vecs[i].exp_v, vecs[i].exp_z);
    end

    // 8-bit signed overflow boundary: 0x7F + 1
    applyStimulus(16'hD07F);
    applyStimulus(16'hD101);
    applyStimulus(16'hA041);
    check("ovf8_out", 32'(out8), 32'h80);
    check("ovf8_nvz", {29'd0, n8, v8, z8}, 32'b110);
    checkOutput("ovf16", 16'h0080, 1'b0, 1'b0, 1'b0);

    // Undefined opcode, then a normal instruction afterwards
    applyStimulus(16'hE000);
    applyStimulus(16'hD00F);
    applyStimulus(16'hC0A0);

    // Reset during GET_B of an ADD aborts it
    applyStimulus(16'hD005);
    in_word  = 16'hA148;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1;
    check_reset_state();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    applyStimulus(16'hC0A0);
    check("abort_r0_zero", 32'(out16), 32'd0);

    for (int i = 0; i < 150; i++) begin
      int sel;
      logic [15:0] wrd;
      sel = $urandom_range(0, 9);
      wrd = 16'($urandom);
      if (sel < 4) begin
        wrd[15:13] = 3'b101;
      end else if (sel < 8) begin
        wrd[15:13] = 3'b110;
        wrd[12]    = 1'($urandom);
        wrd[11]    = 1'b0;
      end
      applyStimulus(wrd);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
